// File: rtl/inst_fetch_if.sv
// Instruction-memory request/ready bus between the fetch unit (master)
// and instruction memory (slave).
interface inst_fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rdata
   );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, fetches one word per REQ/VALID round
// trip, slices it into decode fields and selects the next PC on retire.
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               reset,
   inst_fetch_if.master       imem,
   input  logic               stall,
   input  logic               pc_src,
   input  logic [31:0]        branch_target,
   output logic               inst_valid,
   output logic [3:0]         cond,
   output logic [1:0]         op,
   output logic [5:0]         funct,
   output logic [3:0]         rn,
   output logic [3:0]         rd,
   output logic [3:0]         rm,
   output logic [23:0]        imm24,
   output logic [31:0]        pc,
   output logic [31:0]        pc_plus8,
   output logic [31:0]        retire_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      VALID = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] retire_q, retire_d;
   logic        retire_en;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         pc_q     <= RESET_PC;
         instr_q  <= 32'h0;
         retire_q <= 32'h0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         retire_q <= retire_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      retire_d  = retire_q;
      retire_en = 1'b0;
      case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            if (imem.imem_ready) begin
               instr_d = imem.imem_rdata;
               state_d = VALID;
            end
         end
         VALID: begin
            // Branch inputs are only meaningful on the retire edge.
            if (!stall) begin
               retire_en = 1'b1;
               retire_d  = retire_q + 32'd1;
               pc_d      = pc_src ? (branch_target & 32'hFFFF_FFFC)
                                  : pc_q + 32'd4;
               state_d   = REQ;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign imem.imem_req  = (state_q == REQ);
   assign imem.imem_addr = pc_q;
   assign inst_valid     = (state_q == VALID);

   assign cond  = instr_q[31:28];
   assign op    = instr_q[27:26];
   assign funct = instr_q[25:20];
   assign rn    = instr_q[19:16];
   assign rd    = instr_q[15:12];
   assign rm    = instr_q[3:0];
   assign imm24 = instr_q[23:0];

   assign pc           = pc_q;
   assign pc_plus8     = pc_q + 32'd8;
   assign retire_count = retire_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: boot, sequential fetch, field slicing,
// wait states, stall, branch, PC wrap and asynchronous reset mid-request.
module tb_inst_fetch;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Instance A boots at 0x100, instance B at the top of the address space.
   logic        rst_a, rst_b;
   logic        stall_a, pc_src_a, stall_b, pc_src_b;
   logic [31:0] bt_a, bt_b;

   inst_fetch_if bus_a ();
   inst_fetch_if bus_b ();

   logic        valid_a, valid_b;
   logic [3:0]  cond_a, rn_a, rd_a, rm_a, cond_b, rn_b, rd_b, rm_b;
   logic [1:0]  op_a, op_b;
   logic [5:0]  funct_a, funct_b;
   logic [23:0] imm_a, imm_b;
   logic [31:0] pc_a, p8_a, rc_a, pc_b, p8_b, rc_b;

   inst_fetch #(.RESET_PC(32'h0000_0100)) dut_a (
      .clk(clk), .reset(rst_a), .imem(bus_a.master),
      .stall(stall_a), .pc_src(pc_src_a), .branch_target(bt_a),
      .inst_valid(valid_a), .cond(cond_a), .op(op_a), .funct(funct_a),
      .rn(rn_a), .rd(rd_a), .rm(rm_a), .imm24(imm_a),
      .pc(pc_a), .pc_plus8(p8_a), .retire_count(rc_a)
   );

   inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
      .clk(clk), .reset(rst_b), .imem(bus_b.master),
      .stall(stall_b), .pc_src(pc_src_b), .branch_target(bt_b),
      .inst_valid(valid_b), .cond(cond_b), .op(op_b), .funct(funct_b),
      .rn(rn_b), .rd(rd_b), .rm(rm_b), .imm24(imm_b),
      .pc(pc_b), .pc_plus8(p8_b), .retire_count(rc_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_a = 1'b0; rst_b = 1'b0;
      stall_a = 1'b0; pc_src_a = 1'b0; bt_a = 32'h0;
      stall_b = 1'b0; pc_src_b = 1'b0; bt_b = 32'h0;
      bus_a.imem_ready = 1'b0; bus_a.imem_rdata = 32'h0;
      bus_b.imem_ready = 1'b0; bus_b.imem_rdata = 32'h0;

      // Reset held for 3 cycles
      repeat (3) @(negedge clk);
      chk("rst_req",   32'(bus_a.imem_req), 32'd0);
      chk("rst_valid", 32'(valid_a), 32'd0);
      chk("rst_pc",    pc_a, 32'h100);
      chk("rst_addr",  bus_a.imem_addr, 32'h100);
      chk("rst_rc",    rc_a, 32'd0);
      chk("rst_ir",    {cond_a, imm_a, rm_a}, 32'h0);
      rst_a = 1'b1;

      // First edge after release: IDLE -> REQ
      @(negedge clk);
      chk("boot_req",  32'(bus_a.imem_req), 32'd1);
      chk("boot_addr", bus_a.imem_addr, 32'h100);
      bus_a.imem_ready = 1'b1;
      bus_a.imem_rdata = 32'hE28F_1A05;

      @(negedge clk);
      chk("f0_valid", 32'(valid_a), 32'd1);
      chk("f0_req",   32'(bus_a.imem_req), 32'd0);
      chk("f0_cond",  32'(cond_a), 32'hE);
      chk("f0_op",    32'(op_a), 32'h0);
      chk("f0_funct", 32'(funct_a), 32'h28);
      chk("f0_rn",    32'(rn_a), 32'hF);
      chk("f0_rd",    32'(rd_a), 32'h1);
      chk("f0_rm",    32'(rm_a), 32'h5);
      chk("f0_imm24", 32'(imm_a), 32'h008F_1A05);
      chk("f0_pc",    pc_a, 32'h100);
      chk("f0_pc8",   p8_a, 32'h108);
      bus_a.imem_rdata = 32'h1111_1111;

      @(negedge clk);
      chk("f1_req",  32'(bus_a.imem_req), 32'd1);
      chk("f1_addr", bus_a.imem_addr, 32'h104);
      chk("f1_rc",   rc_a, 32'd1);
      @(negedge clk);
      chk("f1_pc",   pc_a, 32'h104);
      chk("f1_rd",   32'(rd_a), 32'h1);
      @(negedge clk);
      chk("f2_addr", bus_a.imem_addr, 32'h108);
      chk("f2_rc",   rc_a, 32'd2);
      @(negedge clk);
      chk("f2_valid", 32'(valid_a), 32'd1);
      @(negedge clk);
      chk("f3_addr", bus_a.imem_addr, 32'h10C);
      chk("f3_rc",   rc_a, 32'd3);

      // Three memory wait states
      bus_a.imem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("ws_req",   32'(bus_a.imem_req), 32'd1);
         chk("ws_addr",  bus_a.imem_addr, 32'h10C);
         chk("ws_valid", 32'(valid_a), 32'd0);
      end
      bus_a.imem_ready = 1'b1;
      bus_a.imem_rdata = 32'hA1B2_C3D4;
      stall_a = 1'b1;

      @(negedge clk);
      chk("ws_done_valid", 32'(valid_a), 32'd1);
      chk("ws_done_rd",    32'(rd_a), 32'hC);
      chk("ws_done_funct", 32'(funct_a), 32'h1B);
      // Redirect presented during stall must be ignored
      pc_src_a = 1'b1;
      bt_a = 32'h0000_2003;
      bus_a.imem_rdata = 32'h5555_5555;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("st_valid", 32'(valid_a), 32'd1);
         chk("st_req",   32'(bus_a.imem_req), 32'd0);
         chk("st_pc",    pc_a, 32'h10C);
         chk("st_rc",    rc_a, 32'd3);
         chk("st_imm",   32'(imm_a), 32'h00B2_C3D4);
         chk("st_rn",    32'(rn_a), 32'h2);
      end
      stall_a = 1'b0;

      @(negedge clk);
      chk("br_addr", bus_a.imem_addr, 32'h2000);
      chk("br_req",  32'(bus_a.imem_req), 32'd1);
      chk("br_rc",   rc_a, 32'd4);
      pc_src_a = 1'b0;
      @(negedge clk);
      chk("br_pc",   pc_a, 32'h2000);
      chk("br_pc8",  p8_a, 32'h2008);
      chk("br_imm",  32'(imm_a), 32'h0055_5555);

      // Instance B: PC wrap, then async reset mid-REQ
      rst_b = 1'b1;
      @(negedge clk);
      chk("wr_addr0", bus_b.imem_addr, 32'hFFFF_FFFC);
      chk("wr_req0",  32'(bus_b.imem_req), 32'd1);
      bus_b.imem_ready = 1'b1;
      bus_b.imem_rdata = 32'hE3A0_0001;
      @(negedge clk);
      chk("wr_pc8",   p8_b, 32'h0000_0004);
      chk("wr_cond",  32'(cond_b), 32'hE);
      @(negedge clk);
      chk("wr_addr1", bus_b.imem_addr, 32'h0);
      chk("wr_rc",    rc_b, 32'd1);
      chk("wr_req1",  32'(bus_b.imem_req), 32'd1);
      bus_b.imem_rdata = 32'h7777_7777;
      #2 rst_b = 1'b0;
      #1;
      chk("ar_req",   32'(bus_b.imem_req), 32'd0);
      chk("ar_addr",  bus_b.imem_addr, 32'hFFFF_FFFC);
      chk("ar_valid", 32'(valid_b), 32'd0);
      chk("ar_rc",    rc_b, 32'd0);
      chk("ar_ir",    {cond_b, imm_b, rm_b}, 32'h0);
      @(negedge clk);
      chk("ar_nocap", {cond_b, imm_b, rm_b}, 32'h0);
      chk("ar_valid2", 32'(valid_b), 32'd0);
      chk("ar_req2",  32'(bus_b.imem_req), 32'd0);
      chk("ar_rc2",   rc_b, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
